// File: rtl/xeng_pkg.sv
// Shared types and sizing helpers for the X-engine accumulation scheduler.
package xeng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } xeng_state_e;

    function automatic int acc_len(input int serial_acc_len_bits);
        return 1 << serial_acc_len_bits;
    endfunction

    function automatic int n_cmac(input int n_cmac_bits);
        return 1 << n_cmac_bits;
    endfunction

    function automatic int dump_delay(input int mult_latency);
        return mult_latency + 1;
    endfunction

endpackage

// File: rtl/xeng_delay_line.sv
// Fixed-depth single-bit shift register with asynchronous active-low clear.
module xeng_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_sr
        logic [DEPTH-1:0] sr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= '0;
            end else begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end

        assign q = sr[DEPTH-1];
    end

endmodule

// File: rtl/xeng_acc_sched.sv
// Accumulation-window and dump scheduler for a chain of cmac cells
// sharing one output bus.
module xeng_acc_sched
    import xeng_pkg::*;
#(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int N_CMAC_BITS         = 3,
    parameter int MULT_LATENCY        = 4,
    parameter int ACC_MUX_LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sync_in,
    input  logic                   din_valid,
    output logic                   cmac_sync,
    output logic                   cmac_valid,
    output logic                   acc_first,
    output logic                   acc_last,
    output logic [N_CMAC_BITS-1:0] dump_sel,
    output logic                   dump_active,
    output logic                   bus_valid,
    output logic                   resync_err,
    output logic [15:0]            win_cnt
);

    localparam int ACC_LEN    = acc_len(SERIAL_ACC_LEN_BITS);
    localparam int N_CMAC     = n_cmac(N_CMAC_BITS);
    localparam int DUMP_DELAY = dump_delay(MULT_LATENCY);

    localparam logic [SERIAL_ACC_LEN_BITS-1:0] CTR_MAX = '1;
    localparam logic [N_CMAC_BITS-1:0]         SEL_MAX = '1;

    if (N_CMAC > ACC_LEN) begin : g_param_err
        $fatal(1, "xeng_acc_sched: N_CMAC_BITS exceeds SERIAL_ACC_LEN_BITS");
    end

    xeng_state_e                    state_q;
    xeng_state_e                    state_d;
    logic [SERIAL_ACC_LEN_BITS-1:0] samp_ctr;
    logic [SERIAL_ACC_LEN_BITS-1:0] ctr_d;
    logic                           sample;
    logic                           misalign;
    logic                           dump_start;

    always_comb begin
        state_d  = state_q;
        ctr_d    = samp_ctr;
        sample   = 1'b0;
        misalign = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync_in) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (din_valid) begin
                    sample  = 1'b1;
                    ctr_d   = samp_ctr + 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // a sync landing on the completing sample is still aligned
                if (sync_in && samp_ctr != '0 &&
                    !(samp_ctr == CTR_MAX && din_valid)) begin
                    misalign = 1'b1;
                    ctr_d    = '0;
                    state_d  = ARM;
                end else if (din_valid) begin
                    sample = 1'b1;
                    ctr_d  = samp_ctr + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ctr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            samp_ctr   <= '0;
            cmac_sync  <= 1'b0;
            cmac_valid <= 1'b0;
            acc_first  <= 1'b0;
            acc_last   <= 1'b0;
            resync_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_ctr   <= ctr_d;
            cmac_sync  <= sync_in;
            cmac_valid <= sample;
            acc_first  <= sample && (samp_ctr == '0);
            acc_last   <= sample && (samp_ctr == CTR_MAX);
            resync_err <= misalign;
        end
    end

    // one stage of the dump latency is the dump_active register itself
    xeng_delay_line #(
        .DEPTH(DUMP_DELAY - 1)
    ) u_dump_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (acc_last),
        .q    (dump_start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_active <= 1'b0;
            dump_sel    <= '0;
            win_cnt     <= '0;
        end else if (dump_start) begin
            dump_active <= 1'b1;
            dump_sel    <= '0;
        end else if (dump_active) begin
            if (dump_sel == SEL_MAX) begin
                dump_active <= 1'b0;
                dump_sel    <= '0;
                win_cnt     <= win_cnt + 16'd1;
            end else begin
                dump_sel <= dump_sel + 1'b1;
            end
        end
    end

    xeng_delay_line #(
        .DEPTH(ACC_MUX_LATENCY)
    ) u_bus_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (dump_active),
        .q    (bus_valid)
    );

endmodule

// File: tb/tb_xeng_acc_sched.sv
// Directed table-driven bench for xeng_acc_sched (acc len 8, 4 cmac cells).
module tb_xeng_acc_sched;

    localparam int SB  = 3;
    localparam int NB  = 2;
    localparam int ML  = 4;
    localparam int AML = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sync_in = 1'b0;
    logic          din_valid = 1'b0;
    logic          cmac_sync;
    logic          cmac_valid;
    logic          acc_first;
    logic          acc_last;
    logic [NB-1:0] dump_sel;
    logic          dump_active;
    logic          bus_valid;
    logic          resync_err;
    logic [15:0]   win_cnt;
    logic [24:0]   all_o;

    assign all_o = {cmac_sync, cmac_valid, acc_first, acc_last, dump_sel,
                    dump_active, bus_valid, resync_err, win_cnt};

    always #5 clk = ~clk;

    xeng_acc_sched #(
        .SERIAL_ACC_LEN_BITS(SB),
        .N_CMAC_BITS        (NB),
        .MULT_LATENCY       (ML),
        .ACC_MUX_LATENCY    (AML)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_in    (sync_in),
        .din_valid  (din_valid),
        .cmac_sync  (cmac_sync),
        .cmac_valid (cmac_valid),
        .acc_first  (acc_first),
        .acc_last   (acc_last),
        .dump_sel   (dump_sel),
        .dump_active(dump_active),
        .bus_valid  (bus_valid),
        .resync_err (resync_err),
        .win_cnt    (win_cnt)
    );

    typedef enum int {
        F_SY = 0, F_CV, F_AF, F_AL, F_DA, F_SEL, F_BV, F_ERR, F_WIN
    } fld_e;

    typedef struct {
        int   t;
        int   k;
        fld_e f;
        int   v;
    } chk_t;

    typedef struct {
        int t;
        int lo;
        int hi;
        bit s;
        bit v;
    } seg_t;

    chk_t chks[$];
    seg_t segs[$];
    int   tr[64][9];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void ex(int t, int k, fld_e f, int v);
        chk_t c;
        c.t = t; c.k = k; c.f = f; c.v = v;
        chks.push_back(c);
    endfunction

    function automatic void sg(int t, int lo, int hi, bit s, bit v);
        seg_t g;
        g.t = t; g.lo = lo; g.hi = hi; g.s = s; g.v = v;
        segs.push_back(g);
    endfunction

    task automatic compare(string name, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(bit s, bit v, int k);
        sync_in   = s;
        din_valid = v;
        @(posedge clk);
        #1;
        if (k >= 0 && k < 64) begin
            tr[k][int'(F_SY)]  = int'(cmac_sync);
            tr[k][int'(F_CV)]  = int'(cmac_valid);
            tr[k][int'(F_AF)]  = int'(acc_first);
            tr[k][int'(F_AL)]  = int'(acc_last);
            tr[k][int'(F_DA)]  = int'(dump_active);
            tr[k][int'(F_SEL)] = int'(dump_sel);
            tr[k][int'(F_BV)]  = int'(bus_valid);
            tr[k][int'(F_ERR)] = int'(resync_err);
            tr[k][int'(F_WIN)] = int'(win_cnt);
        end
    endtask

    task automatic do_reset(int t);
        sync_in   = 1'b0;
        din_valid = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare($sformatf("t%0d_reset_outputs", t), int'(all_o), 0);
        rst_n = 1'b1;
    endtask

    task automatic run_test(int t, int len);
        bit s;
        bit v;
        for (int k = 0; k < 64; k++)
            for (int f = 0; f < 9; f++)
                tr[k][f] = -1;
        do_reset(t);
        for (int k = 0; k < len; k++) begin
            s = 1'b0;
            v = 1'b0;
            foreach (segs[i]) begin
                if (segs[i].t == t && k >= segs[i].lo && k <= segs[i].hi) begin
                    s = segs[i].s;
                    v = segs[i].v;
                end
            end
            step(s, v, k);
        end
        foreach (chks[i]) begin
            if (chks[i].t == t) begin
                compare($sformatf("t%0d_%s_k%0d", t, chks[i].f.name(), chks[i].k),
                        tr[chks[i].k][int'(chks[i].f)], chks[i].v);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int nbad_pre;
        int first_bv;
        int nbv;
        do_reset(5);
        step(1'b1, 1'b0, -1);
        for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, -1);
        for (int k = 9; k <= 14; k++) step(1'b0, 1'b0, -1);
        compare("t5_dump_active_before_rst", int'(dump_active), 1);
        compare("t5_dump_sel_before_rst", int'(dump_sel), 1);
        rst_n = 1'b0;
        #1;
        compare("t5_async_clear", int'(all_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nbad_pre = 0;
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 1'b1, -1);
            nbad_pre += int'(bus_valid) + int'(cmac_valid) + int'(dump_active);
        end
        compare("t5_quiet_after_release", nbad_pre, 0);
        first_bv = -1;
        nbv = 0;
        for (int j = 0; j <= 20; j++) begin
            step(j == 0, (j >= 1 && j <= 8), -1);
            if (bus_valid && first_bv < 0) first_bv = j;
            nbv += int'(bus_valid);
        end
        compare("t5_first_bus_valid", first_bv, 15);
        compare("t5_bus_valid_width", nbv, 4);
        compare("t5_win_cnt", int'(win_cnt), 1);
    endtask

    initial begin
        // 1: sync, then samples 0..19 at k=1..20
        sg(1, 0, 0, 1, 0);
        sg(1, 1, 20, 0, 1);
        ex(1, 0, F_SY, 1);   ex(1, 0, F_CV, 0);   ex(1, 1, F_CV, 1);
        ex(1, 1, F_AF, 1);   ex(1, 8, F_AF, 0);   ex(1, 9, F_AF, 1);
        ex(1, 17, F_AF, 1);  ex(1, 8, F_AL, 1);   ex(1, 9, F_AL, 0);
        ex(1, 16, F_AL, 1);  ex(1, 12, F_DA, 0);  ex(1, 13, F_DA, 1);
        ex(1, 16, F_DA, 1);  ex(1, 17, F_DA, 0);  ex(1, 13, F_SEL, 0);
        ex(1, 14, F_SEL, 1); ex(1, 15, F_SEL, 2); ex(1, 16, F_SEL, 3);
        ex(1, 14, F_BV, 0);  ex(1, 15, F_BV, 1);  ex(1, 18, F_BV, 1);
        ex(1, 19, F_BV, 0);  ex(1, 16, F_WIN, 0); ex(1, 17, F_WIN, 1);
        ex(1, 21, F_DA, 1);  ex(1, 21, F_SEL, 0); ex(1, 24, F_SEL, 3);
        ex(1, 23, F_BV, 1);  ex(1, 25, F_WIN, 2);
        // 2: 3-cycle gap before sample 4
        sg(2, 0, 0, 1, 0);
        sg(2, 1, 4, 0, 1);
        sg(2, 8, 11, 0, 1);
        ex(2, 5, F_CV, 0);   ex(2, 8, F_CV, 1);   ex(2, 8, F_AF, 0);
        ex(2, 8, F_AL, 0);   ex(2, 11, F_AL, 1);  ex(2, 15, F_DA, 0);
        ex(2, 16, F_DA, 1);  ex(2, 16, F_SEL, 0); ex(2, 19, F_SEL, 3);
        ex(2, 17, F_BV, 0);  ex(2, 18, F_BV, 1);  ex(2, 20, F_WIN, 1);
        // 3: sync at sample 5 (misaligned), later sync at sample 0
        sg(3, 0, 0, 1, 0);
        sg(3, 1, 5, 0, 1);
        sg(3, 6, 6, 1, 1);
        sg(3, 7, 14, 0, 1);
        sg(3, 15, 15, 1, 1);
        ex(3, 5, F_ERR, 0);  ex(3, 6, F_ERR, 1);  ex(3, 7, F_ERR, 0);
        ex(3, 6, F_CV, 0);   ex(3, 6, F_SY, 1);   ex(3, 7, F_AF, 1);
        ex(3, 8, F_AL, 0);   ex(3, 13, F_DA, 0);  ex(3, 14, F_AL, 1);
        ex(3, 15, F_ERR, 0); ex(3, 15, F_AF, 1);  ex(3, 18, F_WIN, 0);
        ex(3, 19, F_DA, 1);  ex(3, 23, F_WIN, 1);
        // 4: resync shortly after acc_last; pending dump survives
        sg(4, 0, 0, 1, 0);
        sg(4, 1, 9, 0, 1);
        sg(4, 10, 10, 1, 1);
        ex(4, 8, F_AL, 1);   ex(4, 9, F_AF, 1);   ex(4, 10, F_ERR, 1);
        ex(4, 11, F_ERR, 0); ex(4, 10, F_CV, 0);  ex(4, 13, F_DA, 1);
        ex(4, 13, F_SEL, 0); ex(4, 16, F_SEL, 3); ex(4, 16, F_DA, 1);
        ex(4, 17, F_DA, 0);  ex(4, 18, F_BV, 1);  ex(4, 17, F_WIN, 1);
        // 6: valid before any sync is ignored
        sg(6, 0, 5, 0, 1);
        sg(6, 6, 6, 1, 0);
        sg(6, 7, 9, 0, 1);
        ex(6, 0, F_AF, 0);   ex(6, 3, F_CV, 0);   ex(6, 5, F_CV, 0);
        ex(6, 4, F_AL, 0);   ex(6, 5, F_AF, 0);   ex(6, 7, F_AF, 1);
        ex(6, 7, F_CV, 1);

        run_test(1, 28);
        run_test(2, 24);
        run_test(3, 24);
        run_test(4, 22);
        test_reset_mid_dump();
        run_test(6, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
